sdr_rd_checker: RTL and testbench

//  Read-side traffic client for sdr_top. Issues burst read requests over a word range,

---
 rtl/sdr_rd_checker.sv | 105 ++++++++++
 tb/tb_sdr_rd_checker.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sdr_rd_checker.sv
// sdr_rd_checker: issues burst reads over a word range and checks each word against seed + index.
// Define SDR_RD_CHK_TIMEOUT_EN to add a watchdog that ends a run when read data stops arriving.
module sdr_rd_checker #(
   parameter int BURST_LEN   = 8,
   parameter int TIMEOUT_CYC = 1024
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic [31:0] base_addr,
   input  logic [11:0] word_cnt,
   input  logic [15:0] seed,
   output logic        busy,
   output logic        done,
   output logic        pass,
   output logic [11:0] err_cnt,
   output logic [31:0] first_err_addr,
   output logic [15:0] first_err_data,
   output logic        timeout,
   output logic        sdr_rd_req,
   output logic [31:0] sdr_raddr,
   input  logic [15:0] sdr_rdata_out,
   input  logic        sdr_rd_vld
);
   typedef enum logic [1:0] {IDLE, REQ, WAIT_DATA, DONE} state_t;
   // idx is the global word index; bursts are aligned, so its low bits are the beat number
   localparam logic [12:0] BEAT_MASK = 13'(BURST_LEN - 1);
   state_t state, state_nx;
   logic [31:0] base;
   logic [15:0] seed_q;
   logic [12:0] cnt, idx;
   logic finished, beat, last_beat, more, bad, wd_fire;

   assign beat = state == WAIT_DATA && sdr_rd_vld;
   assign last_beat = (idx & BEAT_MASK) == BEAT_MASK;
   assign more = idx + 13'd1 < cnt;
   assign bad = beat && idx < cnt && sdr_rdata_out != seed_q + 16'(idx);
   assign busy = state == REQ || state == WAIT_DATA;
   assign done = state == DONE;
   assign sdr_rd_req = state == REQ;
   assign pass = (done || finished) && err_cnt == 12'd0 && !timeout;

`ifdef SDR_RD_CHK_TIMEOUT_EN
   localparam int WDW = $clog2(TIMEOUT_CYC + 1);
   logic [WDW-1:0] wd;
   // counts silent cycles since the last beat (or since start), REQ cycle included
   assign wd_fire = state == WAIT_DATA && !sdr_rd_vld && wd == WDW'(TIMEOUT_CYC - 1);
   always_ff @(posedge clk)
      if (rst || state == IDLE || beat) wd <= '0;
      else if (busy) wd <= wd + 1'b1;
`else
   assign wd_fire = 1'b0;
`endif

   always_comb begin
      state_nx = state;
      if (state == IDLE && start) state_nx = word_cnt == 12'd0 ? DONE : REQ;
      else if (state == REQ) state_nx = WAIT_DATA;
      else if (wd_fire || (beat && last_beat)) state_nx = wd_fire || !more ? DONE : REQ;
      else if (state == DONE) state_nx = IDLE;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state          <= IDLE;
         base           <= '0;
         seed_q         <= '0;
         cnt            <= '0;
         idx            <= '0;
         finished       <= 1'b0;
         err_cnt        <= '0;
         first_err_addr <= '0;
         first_err_data <= '0;
         timeout        <= 1'b0;
         sdr_raddr      <= '0;
      end else begin
         state <= state_nx;
         if (state == IDLE && start) begin
            base           <= base_addr;
            seed_q         <= seed;
            cnt            <= {1'b0, word_cnt};
            idx            <= '0;
            finished       <= 1'b0;
            err_cnt        <= '0;
            first_err_addr <= '0;
            first_err_data <= '0;
            timeout        <= 1'b0;
            sdr_raddr      <= base_addr;
         end
         if (done) finished <= 1'b1;
         if (wd_fire) timeout <= 1'b1;
         if (beat) begin
            idx <= idx + 13'd1;
            if (last_beat && more) sdr_raddr <= sdr_raddr + 32'(BURST_LEN);
         end
         if (bad) begin
            if (err_cnt != 12'hFFF) err_cnt <= err_cnt + 12'd1;
            if (err_cnt == 12'd0) begin
               first_err_addr <= base + 32'(idx);
               first_err_data <= sdr_rdata_out;
            end
         end
      end
   end
endmodule

// File: tb/tb_sdr_rd_checker.sv
// tb_sdr_rd_checker: randomized bench for sdr_rd_checker with a burst-read responder and
// a word-by-word reference model of the expected error report.
module tb_sdr_rd_checker;
   localparam int BL = 8;
   localparam int TO = 1024;
   localparam int BIG = 1 << 30;
   logic clk = 1'b0;
   logic rst, start, busy, done, pass, timeout, sdr_rd_req, sdr_rd_vld;
   logic [31:0] base_addr, first_err_addr, sdr_raddr;
   logic [11:0] word_cnt, err_cnt;
   logic [15:0] seed, first_err_data, sdr_rdata_out;
   int checks = 0, errors = 0, cyc = 0;
   logic [31:0] rsp_base, corrupt_addr, cur;
   logic [15:0] rsp_seed;
   logic corrupt_en;
   int silent_after, n_req, left, dly, last_vld_cyc;
   logic [31:0] req_addr[$];
   int req_cyc[$];
   logic got_done, busy1;
   int start_cyc, done_cyc, exp_err;
   logic [31:0] exp_fa;
   logic [15:0] exp_fd;

   sdr_rd_checker #(.BURST_LEN(BL), .TIMEOUT_CYC(TO)) dut (
      .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .word_cnt(word_cnt),
      .seed(seed), .busy(busy), .done(done), .pass(pass), .err_cnt(err_cnt),
      .first_err_addr(first_err_addr), .first_err_data(first_err_data), .timeout(timeout),
      .sdr_rd_req(sdr_rd_req), .sdr_raddr(sdr_raddr), .sdr_rdata_out(sdr_rdata_out),
      .sdr_rd_vld(sdr_rd_vld)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // memory contents as left by the write side, with one optional corrupted word
   function automatic logic [15:0] stored(input logic [31:0] a);
      return (corrupt_en && a == corrupt_addr) ? 16'hFFFF : rsp_seed + 16'(a - rsp_base);
   endfunction

   // responder: per request, random latency then BL words with random bubbles
   initial begin
      sdr_rd_vld = 1'b0; sdr_rdata_out = '0; left = 0; dly = 0; n_req = 0; cur = '0; last_vld_cyc = 0;
      forever begin
         @(posedge clk); #1;
         sdr_rd_vld = 1'b0;
         if (rst) left = 0;
         else if (left > 0) begin
            if (dly > 0) dly--;
            else if ($urandom_range(3) != 0) begin
               sdr_rd_vld = 1'b1; sdr_rdata_out = stored(cur); cur++; left--; last_vld_cyc = cyc;
            end
         end
         if (!rst && sdr_rd_req) begin
            n_req++; req_addr.push_back(sdr_raddr); req_cyc.push_back(cyc);
            if (n_req <= silent_after) begin cur = sdr_raddr; left = BL; dly = $urandom_range(3); end
         end
      end
   end

   initial begin
      #5_000_000;
      $display("FAIL global_timeout cyc %0d exp finish earlier", cyc);
      $fatal(1);
   end

   // expected error report: walk every checked word
   task automatic model(input logic [31:0] b, input logic [11:0] n, input logic [15:0] s);
      exp_err = 0; exp_fa = '0; exp_fd = '0;
      for (int i = 0; i < int'(n); i++)
         if (stored(b + 32'(i)) !== s + 16'(i)) begin
            if (exp_err == 0) begin exp_fa = b + 32'(i); exp_fd = stored(b + 32'(i)); end
            exp_err++;
         end
   endtask

   task automatic do_run(input logic [31:0] b, input logic [11:0] n, input logic [15:0] s,
                         input int extra, input int budget);
      n_req = 0; req_addr.delete(); req_cyc.delete();
      @(negedge clk);
      base_addr = b; word_cnt = n; seed = s; start = 1'b1; start_cyc = cyc;
      @(negedge clk);
      start = 1'b0; busy1 = busy;
      for (int i = 0; i < extra; i++) begin
         base_addr = $urandom; seed = 16'($urandom); word_cnt = 12'd5; start = 1'b1;
         @(negedge clk);
         start = 1'b0;
      end
      got_done = 1'b0;
      for (int i = 0; i < budget && !got_done; i++)
         if (done) begin got_done = 1'b1; done_cyc = cyc; end
         else @(negedge clk);
   endtask

   task automatic test_reset();
      rst = 1'b1; start = 1'b0; base_addr = '0; word_cnt = '0; seed = '0;
      rsp_base = '0; rsp_seed = '0; corrupt_en = 1'b0; corrupt_addr = '0; silent_after = BIG;
      repeat (3) @(negedge clk);
      checks++;
      if ({busy, done, pass, timeout, sdr_rd_req} !== 5'b0) begin
         errors++; $display("FAIL reset_flags got %b exp 00000", {busy, done, pass, timeout, sdr_rd_req});
      end
      checks++;
      if (err_cnt !== '0 || first_err_addr !== '0 || first_err_data !== '0 || sdr_raddr !== '0) begin
         errors++; $display("FAIL reset_regs got err %h fa %h fd %h ra %h exp all 0",
                            err_cnt, first_err_addr, first_err_data, sdr_raddr);
      end
      rst = 1'b0;
   endtask

   task automatic test_clean();
      int bad = 0;
      rsp_base = '0; rsp_seed = '0; corrupt_en = 1'b0; silent_after = BIG;
      do_run(32'd0, 12'd100, 16'd0, 0, 800);
      checks++; if (!got_done) begin errors++; $display("FAIL clean_done got none exp done"); end
      checks++; if (busy1 !== 1'b1) begin errors++; $display("FAIL clean_busy got %b exp 1", busy1); end
      checks++;
      if (pass !== 1'b1 || err_cnt !== 12'd0) begin
         errors++; $display("FAIL clean_result got pass %b err %0d exp pass 1 err 0", pass, err_cnt);
      end
      checks++; if (n_req != 13) begin errors++; $display("FAIL clean_nreq got %0d exp 13", n_req); end
      foreach (req_addr[k]) if (req_addr[k] != 32'(k * BL)) bad++;
      checks++; if (bad != 0) begin errors++; $display("FAIL clean_raddr got %0d bad addrs exp 0", bad); end
      checks++;
      if (req_cyc.size() == 0 || req_cyc[0] != start_cyc + 1) begin
         errors++; $display("FAIL req_latency got %0d exp %0d", req_cyc.size() ? req_cyc[0] - start_cyc : -1, 1);
      end
      @(negedge clk);
      checks++;
      if (done !== 1'b0 || busy !== 1'b0 || pass !== 1'b1) begin
         errors++; $display("FAIL clean_after got done %b busy %b pass %b exp 0 0 1", done, busy, pass);
      end
   endtask

   task automatic test_error();
      rsp_base = '0; rsp_seed = '0; corrupt_en = 1'b1; corrupt_addr = 32'd37; silent_after = BIG;
      do_run(32'd0, 12'd100, 16'd0, 0, 800);
      checks++;
      if (!got_done || err_cnt !== 12'd1 || pass !== 1'b0) begin
         errors++; $display("FAIL err37_result got done %b err %0d pass %b exp 1 1 0", got_done, err_cnt, pass);
      end
      checks++;
      if (first_err_addr !== 32'd37 || first_err_data !== 16'hFFFF) begin
         errors++; $display("FAIL err37_first got %h/%h exp 00000025/ffff", first_err_addr, first_err_data);
      end
      @(negedge clk);
      checks++; if (pass !== 1'b0) begin errors++; $display("FAIL err37_hold got pass %b exp 0", pass); end
      corrupt_en = 1'b0;
   endtask

   task automatic test_empty();
      do_run(32'h1234, 12'd0, 16'd0, 0, 20);
      checks++;
      if (!got_done || done_cyc != start_cyc + 1) begin
         errors++; $display("FAIL empty_done got %b at +%0d exp 1 at +1", got_done, done_cyc - start_cyc);
      end
      checks++;
      if (pass !== 1'b1 || err_cnt !== 12'd0) begin
         errors++; $display("FAIL empty_result got pass %b err %0d exp 1 0", pass, err_cnt);
      end
      @(negedge clk);
      checks++;
      if (n_req != 0 || done !== 1'b0) begin
         errors++; $display("FAIL empty_after got nreq %0d done %b exp 0 0", n_req, done);
      end
   endtask

   task automatic test_random();
      for (int it = 0; it < 6; it++) begin
         logic [31:0] b;
         logic [11:0] n;
         logic [15:0] s;
         int mode, bad;
         b = it == 0 ? 32'hFFFF_FFF5 : $urandom;
         n = 12'($urandom_range(1, 70));
         s = it == 1 ? 16'hFFF0 : 16'($urandom);
         mode = $urandom_range(2);
         rsp_base = b; rsp_seed = mode == 2 ? s + 16'd3 : s;
         corrupt_en = mode == 1; corrupt_addr = b + 32'($urandom_range(0, int'(n) + BL - 1));
         silent_after = BIG;
         model(b, n, s);
         do_run(b, n, s, 0, 4 * int'(n) + 200);
         checks++; if (!got_done) begin errors++; $display("FAIL rnd%0d_done got none exp done", it); end
         checks++;
         if (err_cnt !== 12'(exp_err) || pass !== (exp_err == 0)) begin
            errors++; $display("FAIL rnd%0d_err got err %0d pass %b exp err %0d pass %b",
                               it, err_cnt, pass, exp_err, exp_err == 0);
         end
         checks++;
         if (first_err_addr !== exp_fa || first_err_data !== exp_fd) begin
            errors++; $display("FAIL rnd%0d_first got %h/%h exp %h/%h", it, first_err_addr, first_err_data, exp_fa, exp_fd);
         end
         bad = 0;
         foreach (req_addr[k]) if (req_addr[k] != b + 32'(k * BL)) bad++;
         checks++;
         if (n_req != (int'(n) + BL - 1) / BL || bad != 0) begin
            errors++; $display("FAIL rnd%0d_reqs got %0d reqs %0d bad exp %0d reqs 0 bad",
                               it, n_req, bad, (int'(n) + BL - 1) / BL);
         end
      end
      corrupt_en = 1'b0;
   endtask

   task automatic test_err_saturate();
      rsp_base = 32'h40; rsp_seed = 16'h1235; corrupt_en = 1'b0; silent_after = BIG;
      do_run(32'h40, 12'hFFF, 16'h1234, 0, 4 * 4095 + 200);
      checks++;
      if (!got_done || err_cnt !== 12'hFFF || pass !== 1'b0) begin
         errors++; $display("FAIL sat_err got done %b err %h pass %b exp 1 fff 0", got_done, err_cnt, pass);
      end
      checks++;
      if (first_err_addr !== 32'h40 || first_err_data !== 16'h1235 || n_req != 512) begin
         errors++; $display("FAIL sat_first got %h/%h nreq %0d exp 00000040/1235 512",
                            first_err_addr, first_err_data, n_req);
      end
   endtask

   task automatic test_timeout();
      rsp_base = '0; rsp_seed = '0; corrupt_en = 1'b0; silent_after = 3;
`ifdef SDR_RD_CHK_TIMEOUT_EN
      do_run(32'd0, 12'd100, 16'd0, 0, 3000);
      checks++;
      if (!got_done || timeout !== 1'b1 || pass !== 1'b0) begin
         errors++; $display("FAIL to_result got done %b timeout %b pass %b exp 1 1 0", got_done, timeout, pass);
      end
      // TO silent cycles follow the last vld cycle, the watchdog result shows on the next one
      checks++;
      if (done_cyc - last_vld_cyc != TO + 1 || n_req != 4) begin
         errors++; $display("FAIL to_timing got gap %0d nreq %0d exp gap %0d nreq 4",
                            done_cyc - last_vld_cyc, n_req, TO + 1);
      end
      @(negedge clk);
      checks++;
      if (timeout !== 1'b1 || busy !== 1'b0) begin
         errors++; $display("FAIL to_hold got timeout %b busy %b exp 1 0", timeout, busy);
      end
`else
      do_run(32'd0, 12'd100, 16'd0, 0, 1500);
      checks++;
      if (got_done || timeout !== 1'b0 || busy !== 1'b1) begin
         errors++; $display("FAIL nowd_wait got done %b timeout %b busy %b exp 0 0 1", got_done, timeout, busy);
      end
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
`endif
      silent_after = BIG;
   endtask

   task automatic test_reset_mid();
      rsp_base = '0; rsp_seed = '0; corrupt_en = 1'b1; corrupt_addr = 32'd5; silent_after = BIG;
      n_req = 0; req_addr.delete(); req_cyc.delete();
      @(negedge clk);
      base_addr = '0; word_cnt = 12'd100; seed = '0; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      for (int i = 0; i < 2000 && n_req < 5; i++) @(negedge clk);
      repeat (3) @(negedge clk);
      checks++;
      if (err_cnt !== 12'd1 || busy !== 1'b1 || sdr_raddr !== 32'd32) begin
         errors++; $display("FAIL mid_pre got err %0d busy %b ra %h exp 1 1 00000020", err_cnt, busy, sdr_raddr);
      end
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      checks++;
      if ({busy, done, pass, timeout, sdr_rd_req} !== 5'b0 || err_cnt !== '0 || first_err_addr !== '0 ||
          first_err_data !== '0 || sdr_raddr !== '0) begin
         errors++; $display("FAIL mid_rst got flags %b err %h fa %h fd %h ra %h exp all 0",
                            {busy, done, pass, timeout, sdr_rd_req}, err_cnt, first_err_addr, first_err_data, sdr_raddr);
      end
      corrupt_en = 1'b0;
      repeat (4) @(negedge clk);
      do_run(32'd0, 12'd100, 16'd0, 0, 800);
      checks++;
      if (!got_done || pass !== 1'b1 || err_cnt !== 12'd0 || n_req != 13) begin
         errors++; $display("FAIL mid_rerun got done %b pass %b err %0d nreq %0d exp 1 1 0 13",
                            got_done, pass, err_cnt, n_req);
      end
   endtask

   task automatic test_back_to_back();
      int dones = 0;
      rsp_base = 32'h100; rsp_seed = 16'hFFFE; corrupt_en = 1'b0; silent_after = BIG;
      do_run(32'h100, 12'd3, 16'hFFFE, 2, 100);
      checks++;
      if (!got_done || pass !== 1'b1 || err_cnt !== 12'd0) begin
         errors++; $display("FAIL wrap_result got done %b pass %b err %0d exp 1 1 0", got_done, pass, err_cnt);
      end
      checks++;
      if (n_req != 1 || req_addr.size() == 0 || req_addr[0] != 32'h100) begin
         errors++; $display("FAIL wrap_req got nreq %0d exp 1 at 00000100", n_req);
      end
      repeat (6) begin
         @(negedge clk);
         if (done) dones++;
      end
      checks++;
      if (dones != 0 || n_req != 1) begin
         errors++; $display("FAIL wrap_single got extra done %0d nreq %0d exp 0 1", dones, n_req);
      end
   endtask

   initial begin
      test_reset();
      test_clean();
      test_error();
      test_empty();
      test_random();
      test_err_saturate();
      test_timeout();
      test_reset_mid();
      test_back_to_back();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
